alu_arbiter: RTL and testbench

//  Shares one combinational 32-bit ALU between NREQ requesters (pipeline port, address unit, debug).

---
 rtl/alu_arbiter_pkg.sv | 27 ++
 rtl/alu_arbiter_rr.sv | 32 +++
 rtl/alu_arbiter.sv | 122 ++++++++++++
 tb/tb_alu_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared ALU op codes, arbiter FSM states and op-legality helper for alu_arbiter.
package alu_arbiter_pkg;

  localparam logic [3:0] ALU_AND    = 4'd0;
  localparam logic [3:0] ALU_OR     = 4'd1;
  localparam logic [3:0] ALU_ADD    = 4'd2;
  localparam logic [3:0] ALU_SUB    = 4'd3;
  localparam logic [3:0] ALU_XOR    = 4'd4;
  localparam logic [3:0] ALU_EQ     = 4'd5;
  localparam logic [3:0] ALU_NE     = 4'd6;
  localparam logic [3:0] ALU_LTU    = 4'd7;
  localparam logic [3:0] ALU_GEU    = 4'd8;
  localparam logic [3:0] ALU_LT     = 4'd9;
  localparam logic [3:0] ALU_GE     = 4'd10;
  localparam logic [3:0] ALU_OP_MAX = 4'd10;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_EXEC = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  function automatic logic is_illegal_op(input logic [3:0] op);
    return op > ALU_OP_MAX;
  endfunction

endpackage

// File: rtl/alu_arbiter_rr.sv
// Round-robin grant: first set request at or above i_ptr, wrapping NREQ-1 -> 0.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDXW = 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDXW-1:0] i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IDXW-1:0] o_idx,
  output logic            o_any
);

  logic [IDXW-1:0] w_j;

  // Scan from the far end back toward i_ptr so the closest request overwrites.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_j     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_j = IDXW'((int'(i_ptr) + k) % NREQ);
      if (i_req[w_j]) begin
        o_grant      = '0;
        o_grant[w_j] = 1'b1;
        o_idx        = w_j;
        o_any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between NREQ requesters; one op in flight, round-robin grant.
// Optional ALU_ARB_ILLEGAL_OP_EN: ops 11..15 bypass the ALU and answer with resp_err.
module alu_arbiter #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_data1,
  input  logic [NREQ*WIDTH-1:0] req_data2,
  input  logic [NREQ*4-1:0]     req_ctrl,
  output logic [WIDTH-1:0]      alu_data1,
  output logic [WIDTH-1:0]      alu_data2,
  output logic [3:0]            alu_ctrl,
  input  logic [WIDTH-1:0]      alu_out,
  output logic [NREQ-1:0]       resp_valid,
  output logic [WIDTH-1:0]      resp_data,
  input  logic [NREQ-1:0]       resp_ready
`ifdef ALU_ARB_ILLEGAL_OP_EN
  ,
  output logic                  resp_err
`endif
);

  import alu_arbiter_pkg::*;

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e       r_state, w_next;
  logic [IDXW-1:0]  r_ptr, r_owner;
  logic [WIDTH-1:0] r_data1, r_data2, r_resp_data;
  logic [3:0]       r_ctrl;
  logic [NREQ-1:0]  w_gnt;
  logic [IDXW-1:0]  w_gnt_idx;
  logic             w_gnt_any;
  logic [3:0]       w_sel_ctrl;
  logic             w_illegal;
  logic             w_resp_ack;

  rr_arbiter #(.NREQ(NREQ), .IDXW(IDXW)) u_rr (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_gnt),
    .o_idx   (w_gnt_idx),
    .o_any   (w_gnt_any)
  );

  assign w_sel_ctrl = req_ctrl[w_gnt_idx*4 +: 4];
  assign w_resp_ack = resp_ready[r_owner];
`ifdef ALU_ARB_ILLEGAL_OP_EN
  assign w_illegal  = is_illegal_op(w_sel_ctrl);
`else
  assign w_illegal  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ARB_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ARB_IDLE: if (w_gnt_any) w_next = w_illegal ? ARB_RESP : ARB_EXEC;
      ARB_EXEC: w_next = ARB_RESP;
      ARB_RESP: if (w_resp_ack) w_next = ARB_IDLE;
      default:  w_next = ARB_IDLE;
    endcase
  end

  // req_ready is masked while reset is held so nothing looks accepted during reset.
  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    if (r_state == ARB_IDLE && rst_n) req_ready = w_gnt;
    if (r_state == ARB_RESP)          resp_valid[r_owner] = 1'b1;
  end

`ifdef ALU_ARB_ILLEGAL_OP_EN
  logic r_err;
  assign resp_err = r_err && (r_state == ARB_RESP);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_owner     <= '0;
      r_data1     <= '0;
      r_data2     <= '0;
      r_ctrl      <= '0;
      r_resp_data <= '0;
`ifdef ALU_ARB_ILLEGAL_OP_EN
      r_err       <= 1'b0;
`endif
    end else begin
      case (r_state)
        ARB_IDLE: if (w_gnt_any) begin
          r_owner <= w_gnt_idx;
          r_data1 <= req_data1[w_gnt_idx*WIDTH +: WIDTH];
          r_data2 <= req_data2[w_gnt_idx*WIDTH +: WIDTH];
          r_ctrl  <= w_sel_ctrl;
`ifdef ALU_ARB_ILLEGAL_OP_EN
          r_err   <= w_illegal;
          if (w_illegal) r_resp_data <= '0;
`endif
        end
        ARB_EXEC: r_resp_data <= alu_out;
        ARB_RESP: if (w_resp_ack)
          r_ptr <= (r_owner == IDXW'(NREQ - 1)) ? '0 : r_owner + 1'b1;
        default: ;
      endcase
    end
  end

  assign alu_data1 = r_data1;
  assign alu_data2 = r_data2;
  assign alu_ctrl  = r_ctrl;
  assign resp_data = r_resp_data;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed, table-driven bench for alu_arbiter with a behavioural ALU attached to its ALU ports.
module tb_alu_arbiter;

  localparam int NREQ  = 2;
  localparam int WIDTH = 32;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_data1;
  logic [NREQ*WIDTH-1:0] req_data2;
  logic [NREQ*4-1:0]     req_ctrl;
  logic [WIDTH-1:0]      alu_data1, alu_data2, alu_out;
  logic [3:0]            alu_ctrl;
  logic [NREQ-1:0]       resp_valid;
  logic [WIDTH-1:0]      resp_data;
  logic [NREQ-1:0]       resp_ready;
`ifdef ALU_ARB_ILLEGAL_OP_EN
  logic                  resp_err;
`endif

  alu_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data1  (req_data1),
    .req_data2  (req_data2),
    .req_ctrl   (req_ctrl),
    .alu_data1  (alu_data1),
    .alu_data2  (alu_data2),
    .alu_ctrl   (alu_ctrl),
    .alu_out    (alu_out),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_ready (resp_ready)
`ifdef ALU_ARB_ILLEGAL_OP_EN
    ,
    .resp_err   (resp_err)
`endif
  );

  always #5 clk = ~clk;

  // External ALU: compares return 0/1, unknown op codes return 0.
  always_comb begin
    alu_out = '0;
    case (alu_ctrl)
      4'd0:  alu_out = alu_data1 & alu_data2;
      4'd1:  alu_out = alu_data1 | alu_data2;
      4'd2:  alu_out = alu_data1 + alu_data2;
      4'd3:  alu_out = alu_data1 - alu_data2;
      4'd4:  alu_out = alu_data1 ^ alu_data2;
      4'd5:  alu_out = {31'd0, alu_data1 == alu_data2};
      4'd6:  alu_out = {31'd0, alu_data1 != alu_data2};
      4'd7:  alu_out = {31'd0, alu_data1 <  alu_data2};
      4'd8:  alu_out = {31'd0, alu_data1 >= alu_data2};
      4'd9:  alu_out = {31'd0, $signed(alu_data1) <  $signed(alu_data2)};
      4'd10: alu_out = {31'd0, $signed(alu_data1) >= $signed(alu_data2)};
      default: alu_out = '0;
    endcase
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic logic [1:0] oh(input int r);
    return 2'(1 << r);
  endfunction

  // Call from IDLE at posedge+1; runs one op on requester r and releases it.
  task automatic do_op(input int r, input logic [3:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input string nm);
    req_valid = '0;
    req_valid[r] = 1'b1;
    req_data1[r*WIDTH +: WIDTH] = a;
    req_data2[r*WIDTH +: WIDTH] = b;
    req_ctrl[r*4 +: 4] = c;
    #1 chk({nm, "_ready"}, 32'(req_ready), 32'(oh(r)));
    @(posedge clk); #1;
    req_valid = '0;
    chk({nm, "_exec_novalid"}, 32'(resp_valid), 32'd0);
    chk({nm, "_alu_data1"}, alu_data1, a);
    chk({nm, "_alu_ctrl"}, 32'(alu_ctrl), 32'(c));
    @(posedge clk); #1;
    chk({nm, "_resp_valid"}, 32'(resp_valid), 32'(oh(r)));
    chk({nm, "_resp_data"}, resp_data, exp);
    resp_ready[r] = 1'b1;
    @(posedge clk); #1;
    resp_ready = '0;
    chk({nm, "_released"}, 32'(resp_valid), 32'd0);
  endtask

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    string       nm;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{4'd2,  32'd5,          32'd7,          32'd12,         "add"};
    vecs[1]  = '{4'd3,  32'd3,          32'd5,          32'hFFFF_FFFE,  "sub_neg"};
    vecs[2]  = '{4'd0,  32'hF0F0_F0F0,  32'h0FF0_0FF0,  32'h00F0_00F0,  "and"};
    vecs[3]  = '{4'd1,  32'h0F00_0000,  32'h0000_00F0,  32'h0F00_00F0,  "or"};
    vecs[4]  = '{4'd4,  32'hFFFF_0000,  32'hFF00_FF00,  32'h00FF_FF00,  "xor"};
    vecs[5]  = '{4'd5,  32'd5,          32'd5,          32'd1,          "eq"};
    vecs[6]  = '{4'd6,  32'd5,          32'd5,          32'd0,          "ne"};
    vecs[7]  = '{4'd7,  32'hFFFF_FFFF,  32'd1,          32'd0,          "ltu"};
    vecs[8]  = '{4'd8,  32'hFFFF_FFFF,  32'd1,          32'd1,          "geu"};
    vecs[9]  = '{4'd9,  32'hFFFF_FFFF,  32'd1,          32'd1,          "lt"};
    vecs[10] = '{4'd10, 32'h8000_0000,  32'd1,          32'd0,          "ge"};
    vecs[11] = '{4'd2,  32'hFFFF_FFFF,  32'd1,          32'd0,          "add_wrap"};

    rst_n = 1'b0;
    resp_ready = '0;
    req_valid = 2'b11;
    req_data1 = {32'd5, 32'd1};
    req_data2 = {32'd7, 32'd2};
    req_ctrl  = {4'd2, 4'd2};

    // Reset with both requesters asserting.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_alu_data1", alu_data1, 32'd0);
    chk("rst_alu_data2", alu_data2, 32'd0);
    chk("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
    rst_n = 1'b1;
    #1 chk("rst_first_grant", 32'(req_ready), 32'b01);
    @(posedge clk); #1;
    req_valid = 2'b10;
    chk("rst_exec_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    chk("rst_op_valid", 32'(resp_valid), 32'b01);
    chk("rst_op_data", resp_data, 32'd3);
    resp_ready = 2'b01;
    @(posedge clk); #1;
    resp_ready = '0;

    // req1 ADD 5+7, still pending from before.
    chk("single_ready", 32'(req_ready), 32'b10);
    @(posedge clk); #1;
    req_valid = '0;
    chk("single_exec", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    chk("single_valid", 32'(resp_valid), 32'b10);
    chk("single_data", resp_data, 32'd12);
    resp_ready = 2'b10;
    @(posedge clk); #1;
    resp_ready = '0;

    for (int i = 0; i < 12; i++)
      do_op(i % 2, vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].nm);

    do_op(1, 4'd2, 32'd100, 32'd1, 32'd101, "ptr_align");

    // Contention: both held, grants alternate every 3 cycles.
    req_data1 = {32'd2, 32'd1};
    req_data2 = {32'd2, 32'd1};
    req_ctrl  = {4'd2, 4'd2};
    req_valid = 2'b11;
    resp_ready = 2'b11;
    #1;
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("cont_grant%0d", g), 32'(req_ready), 32'(oh(g % 2)));
      @(posedge clk); #1;
      chk($sformatf("cont_exec_ready%0d", g), 32'(req_ready), 32'd0);
      chk($sformatf("cont_operand%0d", g), alu_data1, (g % 2) ? 32'd2 : 32'd1);
      @(posedge clk); #1;
      chk($sformatf("cont_valid%0d", g), 32'(resp_valid), 32'(oh(g % 2)));
      chk($sformatf("cont_data%0d", g), resp_data, (g % 2) ? 32'd4 : 32'd2);
      @(posedge clk); #1;
    end
    req_valid = '0;
    resp_ready = '0;

    // Backpressure: signed LT result held while owner stalls; non-owner ready ignored.
    req_data1 = {32'd2, 32'hFFFF_FFFF};
    req_data2 = {32'd2, 32'd1};
    req_ctrl  = {4'd2, 4'd9};
    req_valid = 2'b11;
    #1 chk("bp_grant0", 32'(req_ready), 32'b01);
    @(posedge clk); #1;
    req_valid = 2'b10;
    @(posedge clk); #1;
    resp_ready = 2'b10;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp_hold_valid%0d", c), 32'(resp_valid), 32'b01);
      chk($sformatf("bp_hold_data%0d", c), resp_data, 32'd1);
      chk($sformatf("bp_no_grant%0d", c), 32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end
    resp_ready = 2'b01;
    @(posedge clk); #1;
    resp_ready = '0;
    chk("bp_grant1", 32'(req_ready), 32'b10);
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    chk("bp_req1_valid", 32'(resp_valid), 32'b10);
    chk("bp_req1_data", resp_data, 32'd4);
    resp_ready = 2'b10;
    @(posedge clk); #1;
    resp_ready = '0;

    // Reset during EXEC of SUB 3-5.
    req_data1[31:0] = 32'd3;
    req_data2[31:0] = 32'd5;
    req_ctrl[3:0] = 4'd3;
    req_valid = 2'b01;
    #1 chk("mid_grant", 32'(req_ready), 32'b01);
    @(posedge clk); #1;
    req_valid = '0;
    chk("mid_exec_operand", alu_data1, 32'd3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(resp_valid), 32'd0);
    chk("mid_rst_alu_data1", alu_data1, 32'd0);
    chk("mid_rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("mid_no_resp%0d", c), 32'(resp_valid), 32'd0);
    end
    do_op(1, 4'd2, 32'd10, 32'd20, 32'd30, "post_rst");

    // Op code 12 outside the defined ALU range.
    req_data1[31:0] = 32'd9;
    req_data2[31:0] = 32'd9;
    req_ctrl[3:0] = 4'd12;
    req_valid = 2'b01;
    #1 chk("ill_ready", 32'(req_ready), 32'b01);
    @(posedge clk); #1;
    req_valid = '0;
`ifdef ALU_ARB_ILLEGAL_OP_EN
    chk("ill_valid", 32'(resp_valid), 32'b01);
    chk("ill_err", 32'(resp_err), 32'd1);
    chk("ill_data", resp_data, 32'd0);
    resp_ready = 2'b01;
    @(posedge clk); #1;
    resp_ready = '0;
    chk("ill_released", 32'(resp_valid), 32'd0);
    chk("ill_err_clear", 32'(resp_err), 32'd0);
`else
    chk("ill_exec", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    chk("ill_valid", 32'(resp_valid), 32'b01);
    chk("ill_data", resp_data, 32'd0);
    resp_ready = 2'b01;
    @(posedge clk); #1;
    resp_ready = '0;
    chk("ill_released", 32'(resp_valid), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
